// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit and the sequential ALU.
// The control unit is the master. The ALU is the slave.
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [2:0]       select;
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_hi;
   logic             zero_flag;
   logic             carrier_flag;
   logic             negative_flag;
   logic             overflow_flag;

   modport master (
      output start, select, reg_a, reg_b,
      input  ready, done, out, out_hi,
      input  zero_flag, carrier_flag, negative_flag, overflow_flag
   );

   modport slave (
      input  start, select, reg_a, reg_b,
      output ready, done, out, out_hi,
      output zero_flag, carrier_flag, negative_flag, overflow_flag
   );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU with an IDLE/RUN/DONE handshake.
// Single-step ops finish in one cycle. MUL, DIV and MOD iterate WIDTH times.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic      clk,
   input  logic      reset,
   alu_seq_if.slave  bus
);
   localparam int CW  = $clog2(WIDTH + 1);
   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;
   localparam logic [2:0] OP_AND = 3'd5;
   localparam logic [2:0] OP_OR  = 3'd6;
   localparam logic [2:0] OP_XOR = 3'd7;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [2:0]       op_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic [WIDTH-1:0] out_reg;
   logic [WIDTH-1:0] out_hi_reg;
   logic             zero_reg;
   logic             carry_reg;
   logic             neg_reg;
   logic             ovf_reg;
   logic             done_reg;

   // Single-step results, computed straight from the bus operands.
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [WIDTH-1:0] fast_res;
   logic             fast_c;
   logic             fast_v;
   logic             is_multi;

   always_comb begin
      add_sum  = {1'b0, bus.reg_a} + {1'b0, bus.reg_b};
      sub_diff = {1'b0, bus.reg_a} - {1'b0, bus.reg_b};
      fast_res = '0;
      fast_c   = 1'b0;
      fast_v   = 1'b0;
      case (bus.select)
         OP_ADD: begin
            fast_res = add_sum[WIDTH-1:0];
            fast_c   = add_sum[WIDTH];
            fast_v   = (bus.reg_a[MSB] == bus.reg_b[MSB]) && (fast_res[MSB] != bus.reg_a[MSB]);
         end
         OP_SUB: begin
            fast_res = sub_diff[WIDTH-1:0];
            fast_c   = sub_diff[WIDTH];
            fast_v   = (bus.reg_a[MSB] != bus.reg_b[MSB]) && (fast_res[MSB] != bus.reg_a[MSB]);
         end
         OP_AND:  fast_res = bus.reg_a & bus.reg_b;
         OP_OR:   fast_res = bus.reg_a | bus.reg_b;
         OP_XOR:  fast_res = bus.reg_a ^ bus.reg_b;
         default: fast_res = '0;
      endcase
      is_multi = (bus.select == OP_MUL) || (bus.select == OP_DIV) || (bus.select == OP_MOD);
   end

   // One iteration step.
   // MUL is shift-add on {hi,lo}, with the multiplier held in lo.
   // DIV/MOD is restoring division: the remainder is in hi and the quotient
   // shifts into lo.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_trial;
   logic             div_ok;
   logic [WIDTH-1:0] div_rem;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [WIDTH-1:0] fin_out;
   logic [WIDTH-1:0] fin_hi;
   logic             fin_c;

   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
      div_trial = {hi_reg, lo_reg[MSB]};
      div_ok    = (div_trial >= {1'b0, b_reg});
      div_rem   = div_trial[WIDTH-1:0] - b_reg;
      if (op_reg == OP_MUL) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
      end else begin
         step_hi = div_ok ? div_rem : div_trial[WIDTH-1:0];
         step_lo = {lo_reg[WIDTH-2:0], div_ok};
      end
      // With a zero divisor every trial succeeds.
      // The quotient becomes all ones and the remainder becomes A.
      case (op_reg)
         OP_MUL: begin
            fin_out = step_lo;
            fin_hi  = step_hi;
            fin_c   = |step_hi;
         end
         OP_DIV: begin
            fin_out = step_lo;
            fin_hi  = step_hi;
            fin_c   = (b_reg == '0);
         end
         default: begin
            fin_out = step_hi;
            fin_hi  = step_hi;
            fin_c   = (b_reg == '0);
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         op_reg     <= '0;
         b_reg      <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
         out_reg    <= '0;
         out_hi_reg <= '0;
         zero_reg   <= 1'b0;
         carry_reg  <= 1'b0;
         neg_reg    <= 1'b0;
         ovf_reg    <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  op_reg <= bus.select;
                  b_reg  <= bus.reg_b;
                  if (is_multi) begin
                     hi_reg    <= '0;
                     lo_reg    <= bus.reg_a;
                     cnt_reg   <= CW'(WIDTH);
                     state_reg <= RUN;
                  end else begin
                     out_reg    <= fast_res;
                     out_hi_reg <= '0;
                     zero_reg   <= (fast_res == '0);
                     carry_reg  <= fast_c;
                     neg_reg    <= fast_res[MSB];
                     ovf_reg    <= fast_v;
                     done_reg   <= 1'b1;
                     state_reg  <= DONE;
                  end
               end
            end
            RUN: begin
               hi_reg  <= step_hi;
               lo_reg  <= step_lo;
               cnt_reg <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1)) begin
                  out_reg    <= fin_out;
                  out_hi_reg <= fin_hi;
                  zero_reg   <= (fin_out == '0);
                  carry_reg  <= fin_c;
                  neg_reg    <= fin_out[MSB];
                  ovf_reg    <= 1'b0;
                  done_reg   <= 1'b1;
                  state_reg  <= DONE;
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.ready         = (state_reg == IDLE);
   assign bus.done          = done_reg;
   assign bus.out           = out_reg;
   assign bus.out_hi        = out_hi_reg;
   assign bus.zero_flag     = zero_reg;
   assign bus.carrier_flag  = carry_reg;
   assign bus.negative_flag = neg_reg;
   assign bus.overflow_flag = ovf_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8).
// Expected results come from an arithmetic model and are checked when done pulses.
module tb_alu_seq;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   alu_seq_if #(.WIDTH(W)) bus();

   alu_seq #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int op; int a; int b;
      int out; int hi; int z; int c; int n; int v;
      int lat; int issue_cyc;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int sgn(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   function automatic exp_t model(input int op, input int a, input int b);
      exp_t e;
      int r;
      e = '{op: op, a: a, b: b, out: 0, hi: 0, z: 0, c: 0, n: 0, v: 0, lat: 1, issue_cyc: 0};
      case (op)
         0: begin
            r = a + b;
            e.out = r % 256;
            e.c = (r > 255);
            r = sgn(a) + sgn(b);
            e.v = (r > 127 || r < -128);
         end
         1: begin
            e.out = (a - b + 256) % 256;
            e.c = (a < b);
            r = sgn(a) - sgn(b);
            e.v = (r > 127 || r < -128);
         end
         2: begin
            r = a * b;
            e.out = r % 256;
            e.hi = r / 256;
            e.c = (e.hi != 0);
         end
         3: begin
            if (b == 0) begin e.out = 255; e.hi = a; e.c = 1; end
            else begin e.out = a / b; e.hi = a % b; end
         end
         4: begin
            if (b == 0) begin e.out = a; e.hi = a; e.c = 1; end
            else begin e.out = a % b; e.hi = a % b; end
         end
         5: e.out = a & b;
         6: e.out = a | b;
         default: e.out = a ^ b;
      endcase
      e.z = (e.out == 0);
      e.n = (e.out >= 128);
      if (op >= 2 && op <= 4) e.lat = W + 1;
      return e;
   endfunction

   // Monitor: one line per completed transaction.
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("txn op=%0d a=%0d b=%0d -> out=%0d hi=%0d z=%0b c=%0b n=%0b v=%0b lat=%0d",
                     e.op, e.a, e.b, bus.out, bus.out_hi, bus.zero_flag, bus.carrier_flag,
                     bus.negative_flag, bus.overflow_flag, cyc - e.issue_cyc);
            chk("out",      int'(bus.out), e.out);
            chk("out_hi",   int'(bus.out_hi), e.hi);
            chk("zero",     int'(bus.zero_flag), e.z);
            chk("carrier",  int'(bus.carrier_flag), e.c);
            chk("negative", int'(bus.negative_flag), e.n);
            chk("overflow", int'(bus.overflow_flag), e.v);
            chk("latency",  cyc - e.issue_cyc, e.lat);
         end
      end
   end

   task automatic issue(input int op, input int a, input int b);
      exp_t e;
      int n = 0;
      @(negedge clk);
      while (!bus.ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      bus.start  = 1'b1;
      bus.select = 3'(op);
      bus.reg_a  = 8'(a);
      bus.reg_b  = 8'(b);
      e = model(op, a, b);
      e.issue_cyc = cyc;
      exp_q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      // Operand changes after the start edge must not matter.
      bus.select = 3'($urandom_range(0, 7));
      bus.reg_a  = 8'($urandom);
      bus.reg_b  = 8'($urandom);
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_ready"}, int'(bus.ready), 1);
      chk({tag, "_done"}, int'(bus.done), 0);
      chk({tag, "_out"}, int'(bus.out), 0);
      chk({tag, "_out_hi"}, int'(bus.out_hi), 0);
      chk({tag, "_flags"}, int'({bus.zero_flag, bus.carrier_flag,
                                 bus.negative_flag, bus.overflow_flag}), 0);
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.select = '0;
      bus.reg_a  = '0;
      bus.reg_b  = '0;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      reset = 1'b0;

      // Directed vectors
      issue(0, 200, 100);
      issue(1, 30, 30);
      issue(1, 30, 40);
      issue(0, 100, 100);
      issue(2, 200, 3);
      issue(2, 50, 2);
      issue(3, 150, 5);
      issue(4, 150, 30);
      issue(3, 7, 0);
      issue(4, 9, 0);
      issue(2, 255, 255);
      issue(1, 128, 1);

      // A start while busy must be ignored.
      issue(2, 200, 3);
      for (int k = 0; k < 3; k++) begin
         chk("busy_ready", int'(bus.ready), 0);
         bus.start  = 1'b1;
         bus.select = 3'd0;
         bus.reg_a  = 8'($urandom);
         bus.reg_b  = 8'($urandom);
         @(negedge clk);
      end
      bus.start = 1'b0;

      // Reset in the middle of a DIV.
      issue(3, 150, 7);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check_idle_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      issue(0, 1, 1);

      // Randomized traffic
      for (int t = 0; t < 150; t++) begin
         int op = $urandom_range(0, 7);
         int a  = $urandom_range(0, 255);
         int b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
         issue(op, a, b);
      end

      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
